// File: rtl/mem_ctrl_pkg.sv
// Shared size codes, FSM state encoding and size decode for the byte-serial
// memory controller.
package mem_ctrl_pkg;

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_BYTE = 2'b01;
  localparam logic [1:0] M_HALF = 2'b10;
  localparam logic [1:0] M_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_RD   = 3'd1,
    ST_D_WR   = 3'd2,
    ST_I_RD   = 3'd3,
    ST_D_DONE = 3'd4,
    ST_I_DONE = 3'd5
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      M_BYTE:  return 3'd1;
      M_HALF:  return 3'd2;
      M_WORD:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the little-endian bytes assembled by a load.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (size_i)
      M_BYTE:  data_o = {{24{sign_i & bytes_i[7]}}, bytes_i[7:0]};
      M_HALF:  data_o = {{16{sign_i & bytes_i[15]}}, bytes_i[15:0]};
      default: data_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the MEM
// stage, sequencing word/half/byte accesses as byte-serial RAM cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_re_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_cancel_i,
  output logic              if_busy_o,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic [1:0]        mre_i,
  input  logic              mrsign_i,
  input  logic [1:0]        mwe_i,
  input  logic [31:0]       mwdata_i,
  input  logic [ADDR_W-1:0] ma_i,
  output logic              mem_busy_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  // dv_q: ram_din this cycle belongs to byte k-1 (cleared when a capture edge is frozen)
  logic              dv_q, dv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [2:0]  nbytes;
  logic        is_rd;
  logic [2:0]  ra_idx;
  logic [1:0]  lane;
  logic [31:0] ext_data;

  mem_load_ext u_load_ext (
    .bytes_i (rdata_q),
    .size_i  (size_q),
    .sign_i  (sign_q),
    .data_o  (ext_data)
  );

  always_comb begin
    nbytes   = size_bytes(size_q);
    is_rd    = (state_q == ST_D_RD) || (state_q == ST_I_RD);
    ra_idx   = (is_rd && !dv_q && rdy) ? k_q - 3'd1 : k_q;
    lane     = 2'(k_q - 3'd1);
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    if (is_rd || state_q == ST_D_WR) ram_a = addr_q + ADDR_W'(ra_idx);
    if (state_q == ST_D_WR) begin
      ram_wr   = rdy;
      ram_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
    end

    mem_done_o = (state_q == ST_D_DONE);
    mem_data_o = mem_done_o ? ext_data : '0;
    if_done_o  = (state_q == ST_I_DONE) && !if_cancel_i;
    if_data_o  = if_done_o ? rdata_q : '0;
    if_busy_o  = if_re_i && !if_done_o;
    mem_busy_o = ((mre_i != M_NONE) || (mwe_i != M_NONE)) && !mem_done_o;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dv_d    = dv_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (rdy && (mwe_i != M_NONE || mre_i != M_NONE || (if_re_i && !if_cancel_i))) begin
          k_d     = '0;
          dv_d    = 1'b1;
          rdata_d = '0;
          if (mwe_i != M_NONE) begin
            state_d = ST_D_WR;
            size_d  = mwe_i;
            addr_d  = ma_i;
            wdata_d = mwdata_i;
          end else if (mre_i != M_NONE) begin
            state_d = ST_D_RD;
            size_d  = mre_i;
            sign_d  = mrsign_i;
            addr_d  = ma_i;
          end else begin
            state_d = ST_I_RD;
            size_d  = M_WORD;
            sign_d  = 1'b0;
            addr_d  = if_addr_i;
          end
        end
      end
      ST_D_RD, ST_I_RD: begin
        if (!rdy) begin
          if (k_q != 3'd0) dv_d = 1'b0;
        end else if (state_q == ST_I_RD && if_cancel_i) begin
          state_d = ST_IDLE;
        end else if (!dv_q) begin
          dv_d = 1'b1;
        end else begin
          if (k_q != 3'd0) rdata_d[{lane, 3'b000} +: 8] = ram_din;
          if (k_q == nbytes) state_d = (state_q == ST_D_RD) ? ST_D_DONE : ST_I_DONE;
          else k_d = k_q + 3'd1;
        end
      end
      ST_D_WR: begin
        if (rdy) begin
          if (k_q == nbytes - 3'd1) state_d = ST_D_DONE;
          else k_d = k_q + 3'd1;
        end
      end
      ST_D_DONE, ST_I_DONE: begin
        if (rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dv_q    <= dv_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    sign_q  <= sign_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a small synchronous byte RAM model.
module tb_mem_ctrl;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              if_re_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_cancel_i;
  logic              if_busy_o;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic [1:0]        mre_i;
  logic              mrsign_i;
  logic [1:0]        mwe_i;
  logic [31:0]       mwdata_i;
  logic [ADDR_W-1:0] ma_i;
  logic              mem_busy_o;
  logic [31:0]       mem_data_o;
  logic              mem_done_o;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_re_i(if_re_i), .if_addr_i(if_addr_i), .if_cancel_i(if_cancel_i),
    .if_busy_o(if_busy_o), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mre_i(mre_i), .mrsign_i(mrsign_i), .mwe_i(mwe_i), .mwdata_i(mwdata_i),
    .ma_i(ma_i), .mem_busy_o(mem_busy_o), .mem_data_o(mem_data_o),
    .mem_done_o(mem_done_o), .ram_a(ram_a), .ram_dout(ram_dout),
    .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // RAM model: read data appears the cycle after its address
  logic [7:0]  ram [0:1023];
  logic [9:0]  ridx;
  logic [7:0]  rd_q;
  int          wn = 0;
  logic [31:0] wa [0:15];
  logic [7:0]  wd [0:15];

  assign ridx    = 10'(ram_a & 32'h3FF);
  assign ram_din = rd_q;

  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ridx] <= ram_dout;
      if (wn < 16) begin
        wa[wn] = ram_a;
        wd[wn] = ram_dout;
      end
      wn = wn + 1;
    end
    rd_q <= ram[ridx];
  end

  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] ra_log [0:31];
  logic        if_busy_all;
  logic        seen_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts cycles after the accept edge until the chosen done pulse (0 = timeout)
  task automatic wait_done(input bit is_if, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      ra_log[i] = ram_a;
      if_busy_all = if_busy_all & if_busy_o;
      if (is_if ? if_done_o : mem_done_o) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic end_op();
    mre_i = 2'b00; mwe_i = 2'b00; if_re_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int cyc;
  int wbase;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h007] = 8'h80;
    ram[10'h3FF] = 8'h34; ram[10'h000] = 8'h92;
    ram[10'h300] = 8'h13; ram[10'h301] = 8'h00; ram[10'h302] = 8'h00; ram[10'h303] = 8'h6F;
    ram[10'h304] = 8'hB3; ram[10'h305] = 8'h05; ram[10'h306] = 8'h00; ram[10'h307] = 8'h00;
    rst = 1'b0; rdy = 1'b1; if_re_i = 1'b0; if_addr_i = '0; if_cancel_i = 1'b0;
    mre_i = 2'b00; mrsign_i = 1'b0; mwe_i = 2'b00; mwdata_i = '0; ma_i = '0;
    if_busy_all = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
    check("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
    check("rst_dones", {30'b0, mem_done_o, if_done_o}, 32'h0);
    check("rst_data", mem_data_o | if_data_o, 32'h0);
    rst = 1'b1;
    step();

    // word load 0x100
    mre_i = 2'b11; ma_i = 32'h100;
    wait_done(1'b0, cyc);
    check("wl_cycles", cyc, 6);
    check("wl_a0", ra_log[1], 32'h100);
    check("wl_a1", ra_log[2], 32'h101);
    check("wl_a2", ra_log[3], 32'h102);
    check("wl_a3", ra_log[4], 32'h103);
    check("wl_data", mem_data_o, 32'h44332211);
    check("wl_busy_done", {31'b0, mem_busy_o}, 32'h0);
    end_op();
    check("wl_done_pulse", {31'b0, mem_done_o}, 32'h0);

    // byte loads, signed then unsigned
    mre_i = 2'b01; ma_i = 32'h7; mrsign_i = 1'b1;
    wait_done(1'b0, cyc);
    check("bl_cycles", cyc, 3);
    check("bl_signed", mem_data_o, 32'hFFFFFF80);
    end_op();
    mre_i = 2'b01; ma_i = 32'h7; mrsign_i = 1'b0;
    wait_done(1'b0, cyc);
    check("bl_unsigned", mem_data_o, 32'h00000080);
    end_op();

    // signed half load wrapping past the top of the address space
    mre_i = 2'b10; ma_i = 32'hFFFF_FFFF; mrsign_i = 1'b1;
    wait_done(1'b0, cyc);
    check("hl_cycles", cyc, 4);
    check("hl_a0", ra_log[1], 32'hFFFF_FFFF);
    check("hl_a1_wrap", ra_log[2], 32'h0);
    check("hl_data", mem_data_o, 32'hFFFF9234);
    end_op();

    // half store
    wbase = wn;
    mwe_i = 2'b10; ma_i = 32'h202; mwdata_i = 32'hDEADBEEF;
    wait_done(1'b0, cyc);
    check("hs_cycles", cyc, 3);
    check("hs_wr_in_done", {31'b0, ram_wr}, 32'h0);
    check("hs_nwrites", wn - wbase, 2);
    check("hs_w0", {wa[wbase], 24'b0} | {24'b0, wd[wbase]}, {32'h202, 24'b0} | 32'hEF);
    check("hs_w0_addr", wa[wbase], 32'h202);
    check("hs_w0_data", {24'b0, wd[wbase]}, 32'hEF);
    check("hs_w1_addr", wa[wbase+1], 32'h203);
    check("hs_w1_data", {24'b0, wd[wbase+1]}, 32'hBE);
    end_op();

    // MEM and IF word loads requested together
    mre_i = 2'b11; ma_i = 32'h100; if_re_i = 1'b1; if_addr_i = 32'h300;
    if_busy_all = 1'b1;
    wait_done(1'b0, cyc);
    check("arb_mem_cycles", cyc, 6);
    check("arb_mem_data", mem_data_o, 32'h44332211);
    check("arb_if_busy", {31'b0, if_busy_all}, 32'h1);
    mre_i = 2'b00;
    step();
    check("arb_if_busy_idle", {31'b0, if_busy_o}, 32'h1);
    wait_done(1'b1, cyc);
    check("arb_if_cycles", cyc, 6);
    check("arb_if_a0", ra_log[1], 32'h300);
    check("arb_if_data", if_data_o, 32'h6F000013);
    check("arb_if_busy_done", {31'b0, if_busy_o}, 32'h0);
    end_op();

    // cancel an IF fetch at k=2, then fetch from the branch target
    if_re_i = 1'b1; if_addr_i = 32'h300;
    seen_bad = 1'b0;
    repeat (3) begin
      step();
      seen_bad = seen_bad | if_done_o;
    end
    if_cancel_i = 1'b1;
    #1;
    seen_bad = seen_bad | if_done_o;
    step();
    seen_bad = seen_bad | if_done_o;
    if_cancel_i = 1'b0; if_addr_i = 32'h304;
    check("cancel_no_done", {31'b0, seen_bad}, 32'h0);
    wait_done(1'b1, cyc);
    check("cancel_restart_cycles", cyc, 6);
    check("cancel_restart_a0", ra_log[1], 32'h304);
    check("cancel_restart_data", if_data_o, 32'h000005B3);
    end_op();

    // word store frozen for 3 cycles after its first byte
    wbase = wn;
    mwe_i = 2'b11; ma_i = 32'h210; mwdata_i = 32'h11223344;
    step();
    step();
    rdy = 1'b0;
    seen_bad = 1'b0;
    repeat (3) begin
      #1;
      seen_bad = seen_bad | ram_wr;
      step();
    end
    rdy = 1'b1;
    check("frz_no_wr", {31'b0, seen_bad}, 32'h0);
    wait_done(1'b0, cyc);
    check("frz_done_seen", {31'b0, mem_done_o}, 32'h1);
    check("frz_nwrites", wn - wbase, 4);
    check("frz_w0", {wa[wbase], wd[wbase]} == {32'h210, 8'h44} ? 32'h1 : 32'h0, 32'h1);
    check("frz_w1", {wa[wbase+1], wd[wbase+1]} == {32'h211, 8'h33} ? 32'h1 : 32'h0, 32'h1);
    check("frz_w2", {wa[wbase+2], wd[wbase+2]} == {32'h212, 8'h22} ? 32'h1 : 32'h0, 32'h1);
    check("frz_w3", {wa[wbase+3], wd[wbase+3]} == {32'h213, 8'h11} ? 32'h1 : 32'h0, 32'h1);
    end_op();

    // word load frozen across a capture edge
    mre_i = 2'b11; ma_i = 32'h100;
    repeat (3) step();
    rdy = 1'b0;
    repeat (2) step();
    rdy = 1'b1;
    wait_done(1'b0, cyc);
    check("frz_rd_done_seen", {31'b0, mem_done_o}, 32'h1);
    check("frz_rd_data", mem_data_o, 32'h44332211);
    end_op();

    // asynchronous reset in the middle of a read
    mre_i = 2'b11; ma_i = 32'h100;
    repeat (3) step();
    rst = 1'b0;
    mre_i = 2'b00;
    #1;
    check("arst_ram_a", ram_a, 32'h0);
    check("arst_ram_wr", {31'b0, ram_wr}, 32'h0);
    check("arst_mem_busy", {31'b0, mem_busy_o}, 32'h0);
    step();
    rst = 1'b1;
    seen_bad = 1'b0;
    repeat (8) begin
      step();
      seen_bad = seen_bad | mem_done_o | if_done_o;
    end
    check("arst_no_done", {31'b0, seen_bad}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
